// File: rtl/conv_engine_2d.sv
// conv_engine_2d
//
// Streaming 3x3 Sobel-X convolution over a raster-scanned 8-bit grayscale
// frame. Pixels arrive one per cycle after a start pulse. Two line buffers
// supply the two rows above the incoming pixel. A 3x3 window register holds
// the current neighbourhood. A two-stage pipeline (products, then sum)
// produces one signed result per fully covered window. After the last
// result, done_signal pulses once.
//
// Ports:
//   clk          - single clock, rising edge
//   rst          - asynchronous, active-low reset
//   start_signal - one-cycle pulse, begins (or restarts) a frame
//   pixel_valid  - pixel_in is valid this cycle
//   pixel_in     - unsigned 8-bit pixel, raster order
//   result_out   - signed 22-bit convolution result (held when not valid)
//   result_valid - result_out valid this cycle
//   done_signal  - one-cycle pulse when the frame is complete

`timescale 1ns/1ps

module conv_engine_2d #(
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_signal,
  input  logic               pixel_valid,
  input  logic [7:0]         pixel_in,
  output logic signed [21:0] result_out,
  output logic               result_valid,
  output logic               done_signal
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      col_q, col_d;
  logic [RW-1:0]      row_q, row_d;
  logic               win_valid_q, win_valid_d;
  logic               prod_valid_q, prod_valid_d;
  logic               result_valid_q, result_valid_d;
  logic signed [21:0] result_q, result_d;
  logic               done_q, done_d;

  // Line buffers: lb_top holds row r-2, lb_mid holds row r-1 while row r streams in.
  logic [7:0] lb_top_mem [IMG_WIDTH];
  logic [7:0] lb_mid_mem [IMG_WIDTH];

  // Window: win_q[row][col], row 0 = top, col 2 = newest column.
  logic [7:0] win_q [3][3];
  logic [7:0] win_d [3][3];

  // Only the outer columns carry non-zero Sobel-X weights, so six products.
  logic signed [10:0] prod_q [6];
  logic signed [10:0] prod_d [6];
  logic signed [21:0] sum;

  logic accept;

  // start wins over a coincident pixel; pixels outside RUN are ignored.
  assign accept = (state_q == S_RUN) && pixel_valid && !start_signal;

  // Window shift: the new column is the two buffered rows plus the live pixel.
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int i = 0; i < 3; i++) begin
        win_d[i][0] = win_q[i][1];
        win_d[i][1] = win_q[i][2];
      end
      win_d[0][2] = lb_top_mem[col_q];
      win_d[1][2] = lb_mid_mem[col_q];
      win_d[2][2] = pixel_in;
    end
  end

  // Kernel [-1 0 +1; -2 0 +2; -1 0 +1] applied to zero-extended pixels.
  always_comb begin
    prod_d[0] = -$signed({3'b000, win_q[0][0]});
    prod_d[1] = -$signed({2'b00, win_q[1][0], 1'b0});
    prod_d[2] = -$signed({3'b000, win_q[2][0]});
    prod_d[3] =  $signed({3'b000, win_q[0][2]});
    prod_d[4] =  $signed({2'b00, win_q[1][2], 1'b0});
    prod_d[5] =  $signed({3'b000, win_q[2][2]});
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < 6; k++) begin
      sum = sum + {{11{prod_q[k][10]}}, prod_q[k]};
    end
  end

  // Control: counters, FSM next state, pipeline valid tags and outputs.
  always_comb begin
    state_d        = state_q;
    col_d          = col_q;
    row_d          = row_q;
    done_d         = 1'b0;
    win_valid_d    = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
    prod_valid_d   = win_valid_q;
    result_valid_d = prod_valid_q;
    result_d       = prod_valid_q ? sum : result_q;

    if (start_signal) begin
      // Restart from any state; in-flight results are discarded.
      state_d        = S_RUN;
      col_d          = '0;
      row_d          = '0;
      win_valid_d    = 1'b0;
      prod_valid_d   = 1'b0;
      result_valid_d = 1'b0;
      result_d       = result_q;
    end else begin
      unique case (state_q)
        S_IDLE: begin
        end
        S_RUN: begin
          if (pixel_valid) begin
            if (col_q == COL_LAST) begin
              col_d = '0;
              if (row_q == ROW_LAST) begin
                row_d   = '0;
                state_d = S_FLUSH;
              end else begin
                row_d = row_q + RW'(1);
              end
            end else begin
              col_d = col_q + CW'(1);
            end
          end
        end
        S_FLUSH: begin
          // Once the last result occupies the output stage, the next cycle is done.
          if (!win_valid_q && !prod_valid_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      col_q          <= '0;
      row_q          <= '0;
      win_valid_q    <= 1'b0;
      prod_valid_q   <= 1'b0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      row_q          <= row_d;
      win_valid_q    <= win_valid_d;
      prod_valid_q   <= prod_valid_d;
      result_valid_q <= result_valid_d;
      result_q       <= result_d;
      done_q         <= done_d;
    end
  end

  // Datapath storage needs no reset: every entry is written before it is used.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_top_mem[col_q] <= lb_mid_mem[col_q];
      lb_mid_mem[col_q] <= pixel_in;
    end
    win_q  <= win_d;
    prod_q <= prod_d;
  end

  assign result_out   = result_q;
  assign result_valid = result_valid_q;
  assign done_signal  = done_q;

endmodule

// File: tb/tb_conv_engine_2d.sv
// tb_conv_engine_2d
//
// Drives directed frames (ramp, stripe, box, gapped ramp, aborted frame,
// inverse ramp) into conv_engine_2d. The driver pushes each expected result
// and its arrival cycle into a scoreboard queue; a monitor pops and compares
// whenever result_valid or done_signal is seen.

`timescale 1ns/1ps

module tb_conv_engine_2d;

  localparam int W = 32;
  localparam int H = 32;

  logic               clk;
  logic               rst;
  logic               start_signal;
  logic               pixel_valid;
  logic [7:0]         pixel_in;
  logic signed [21:0] result_out;
  logic               result_valid;
  logic               done_signal;

  typedef struct {
    longint val;
    longint cyc;
  } exp_t;

  exp_t   exp_q[$];
  longint done_exp[$];
  longint last_res;
  int     cyc;
  int     vectors;
  int     miscompares;

  conv_engine_2d #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_signal(start_signal),
    .pixel_valid (pixel_valid),
    .pixel_in    (pixel_in),
    .result_out  (result_out),
    .result_valid(result_valid),
    .done_signal (done_signal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after rising edge k, cyc == k.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame kinds: 0 ramp, 1 vertical stripe, 2 box, 3 inverse ramp.
  function automatic logic [7:0] pix(input int kind, input int c);
    case (kind)
      0:       return 8'(c);
      1:       return (c < 16) ? 8'd0 : 8'd255;
      2:       return 8'd255;
      default: return 8'(255 - c);
    endcase
  endfunction

  // Hand-derived results indexed by the bottom-right column c of the window.
  function automatic longint exp_val(input int kind, input int c);
    case (kind)
      0:       return 8;
      1:       return (c == 16 || c == 17) ? 1020 : 0;
      2:       return 0;
      default: return -8;
    endcase
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: compares every presented result and done pulse against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (result_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious result_valid", longint'(result_valid), 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("result value", longint'($signed(result_out)), e.val);
          checkOutput("result cycle", cyc, e.cyc);
          last_res = e.val;
        end
      end else begin
        checkOutput("result hold", longint'($signed(result_out)), last_res);
      end
      if (done_signal) begin
        if (done_exp.size() == 0) begin
          checkOutput("spurious done_signal", longint'(done_signal), 0);
        end else begin
          checkOutput("done cycle", cyc, done_exp.pop_front());
        end
      end
    end
  end

  // Drives one frame. gapped drops pixel_valid every third slot; abort_after >= 0
  // asserts reset once that many pixels have been accepted.
  task automatic applyStimulus(input int kind, input bit gapped, input int abort_after);
    int n;
    int r;
    int c;
    int slot;
    n = 0;
    r = 0;
    c = 0;
    slot = 0;

    // Pixels offered while idle must be ignored.
    repeat (3) begin
      @(posedge clk); #1;
      pixel_valid = 1'b1;
      pixel_in    = 8'($urandom_range(0, 255));
    end

    // Start with a coincident pixel that must be dropped.
    @(posedge clk); #1;
    start_signal = 1'b1;
    pixel_valid  = 1'b1;
    pixel_in     = 8'hAA;
    @(posedge clk); #1;
    start_signal = 1'b0;

    while (n < W * H) begin
      if (abort_after >= 0 && n == abort_after) begin
        rst = 1'b0;
        #1;
        checkOutput("abort result_out", longint'($signed(result_out)), 0);
        checkOutput("abort result_valid", longint'(result_valid), 0);
        checkOutput("abort done_signal", longint'(done_signal), 0);
        exp_q.delete();
        done_exp.delete();
        last_res = 0;
        pixel_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        return;
      end
      if (gapped && (slot % 3 == 2)) begin
        pixel_valid = 1'b0;
        pixel_in    = 8'h55;
      end else begin
        pixel_valid = 1'b1;
        pixel_in    = pix(kind, c);
        // Sampled at edge cyc+1; result after edge +2, done after edge +3.
        if (r >= 2 && c >= 2) exp_q.push_back('{val: exp_val(kind, c), cyc: cyc + 3});
        if (n == W * H - 1) done_exp.push_back(cyc + 4);
        n++;
        if (c == W - 1) begin
          c = 0;
          r++;
        end else begin
          c++;
        end
      end
      slot++;
      @(posedge clk); #1;
    end

    // Pixels offered after the frame must be ignored.
    repeat (6) begin
      pixel_valid = 1'b1;
      pixel_in    = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
    end
    pixel_valid = 1'b0;

    for (int k = 0; k < 40 && (exp_q.size() != 0 || done_exp.size() != 0); k++) begin
      @(posedge clk); #1;
    end
    checkOutput("frame drained", exp_q.size() + done_exp.size(), 0);
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    last_res     = 0;
    rst          = 1'b0;
    start_signal = 1'b0;
    pixel_valid  = 1'b0;
    pixel_in     = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset result_out", longint'($signed(result_out)), 0);
    checkOutput("reset result_valid", longint'(result_valid), 0);
    checkOutput("reset done_signal", longint'(done_signal), 0);
    rst = 1'b1;

    $display("[TB] ramp frame");
    applyStimulus(0, 1'b0, -1);
    $display("[TB] vertical stripe frame");
    applyStimulus(1, 1'b0, -1);
    $display("[TB] box frame");
    applyStimulus(2, 1'b0, -1);
    $display("[TB] gapped ramp frame");
    applyStimulus(0, 1'b1, -1);
    $display("[TB] ramp frame aborted by reset after 500 pixels");
    applyStimulus(0, 1'b0, 500);
    $display("[TB] box frame after reset");
    applyStimulus(2, 1'b0, -1);
    $display("[TB] back-to-back ramp and inverse ramp");
    applyStimulus(0, 1'b0, -1);
    applyStimulus(3, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
